// File: rtl/as_ctrl_seq.sv
// as_ctrl_seq: multi-cycle control sequencer for a small accumulator/ALU datapath.
//   Fetches 16-bit instructions from a synchronous ROM (pc -> instr, one cycle
//   read latency), decodes them into datapath control strobes, and branches on
//   a captured copy of the ALU zero flag. Supports free-run and single-step.
//
// Ports
//   clk, reset      system clock; synchronous active-high reset
//   run, step       run=1 free-runs; with run=0 each step pulse releases one instruction
//   instr           ROM read data (valid the cycle after pc is presented)
//   z               ALU zero flag from the current adder output
//   pc              instruction address to the ROM
//   rd_addr/rs_addr register-file addresses from IR[11:10] / IR[9:8]
//   immediate       IR[7:0] sign-extended or truncated to n bits
//   reg_we, add_a_sel, add_b_sel, acc_en, acc_add, in_en
//                   datapath strobes, only ever high during EXECUTE
//   halted          high while parked in HALT
//   illegal         sticky flag: an undefined opcode was executed
module as_ctrl_seq #(
    parameter int n      = 8,
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              run,
    input  logic              step,
    input  logic [15:0]       instr,
    input  logic              z,
    output logic [ADDR_W-1:0] pc,
    output logic [1:0]        rd_addr,
    output logic [1:0]        rs_addr,
    output logic [n-1:0]      immediate,
    output logic              reg_we,
    output logic              add_a_sel,
    output logic              add_b_sel,
    output logic              acc_en,
    output logic              acc_add,
    output logic              in_en,
    output logic              halted,
    output logic              illegal
);

    typedef enum logic [1:0] {
        S_FETCH  = 2'd0,
        S_DECODE = 2'd1,
        S_EXEC   = 2'd2,
        S_HALT   = 2'd3
    } state_t;

    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_ADDI = 4'h1;
    localparam logic [3:0] OP_MACI = 4'h2;
    localparam logic [3:0] OP_IN   = 4'h3;
    localparam logic [3:0] OP_ACCI = 4'h4;
    localparam logic [3:0] OP_ACCM = 4'h5;
    localparam logic [3:0] OP_BSW  = 4'h6;
    localparam logic [3:0] OP_JMP  = 4'h7;
    localparam logic [3:0] OP_BZ   = 4'h8;
    localparam logic [3:0] OP_HALT = 4'hF;

    localparam logic [ADDR_W-1:0] PC_ONE = 1;

    state_t            state, state_nx;
    logic [15:0]       ir;
    logic              z_flag;
    logic [3:0]        op;
    logic [ADDR_W-1:0] pc_inc;
    logic [ADDR_W-1:0] jmp_tgt;
    logic [ADDR_W-1:0] pc_nx;
    logic              op_illegal;
    logic              op_sets_z;

    assign op      = ir[15:12];
    assign rd_addr = ir[11:10];
    assign rs_addr = ir[9:8];
    assign pc_inc  = pc + PC_ONE;   // natural wrap at 2**ADDR_W

    // Immediate is the 8-bit IR field widened (sign-extended) or cut to n bits.
    generate
        if (n == 8) begin : g_imm_eq
            assign immediate = ir[7:0];
        end else if (n > 8) begin : g_imm_ext
            assign immediate = {{(n-8){ir[7]}}, ir[7:0]};
        end else begin : g_imm_trunc
            assign immediate = ir[n-1:0];
        end
    endgenerate

    // Branch target is the low ADDR_W bits of the (widened) immediate.
    generate
        if (ADDR_W <= n) begin : g_tgt_trunc
            assign jmp_tgt = immediate[ADDR_W-1:0];
        end else begin : g_tgt_ext
            assign jmp_tgt = {{(ADDR_W-n){immediate[n-1]}}, immediate};
        end
    endgenerate

    assign op_illegal = (op >= 4'h9) && (op <= 4'hE);
    assign op_sets_z  = (op == OP_ADDI) || (op == OP_MACI) || (op == OP_ACCI) ||
                        (op == OP_ACCM) || (op == OP_BSW);

    // BZ tests the flag captured by an earlier instruction, never the live z.
    always_comb begin
        pc_nx = pc_inc;
        case (op)
            OP_JMP:  pc_nx = jmp_tgt;
            OP_BZ:   pc_nx = z_flag ? jmp_tgt : pc_inc;
            OP_HALT: pc_nx = pc;
            default: pc_nx = pc_inc;
        endcase
    end

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk) begin
        if (reset) state <= S_FETCH;
        else       state <= state_nx;
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_nx = state;
        case (state)
            S_FETCH:  if (run || step) state_nx = S_DECODE;
            S_DECODE: state_nx = S_EXEC;
            S_EXEC:   state_nx = (op == OP_HALT) ? S_HALT : S_FETCH;
            S_HALT:   state_nx = S_HALT;
            default:  state_nx = S_FETCH;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    // Strobes are gated by reset so a reset landing in EXECUTE never produces a
    // partial write.
    always_comb begin
        reg_we    = 1'b0;
        add_a_sel = 1'b0;
        add_b_sel = 1'b0;
        acc_en    = 1'b0;
        acc_add   = 1'b0;
        in_en     = 1'b0;
        if (state == S_EXEC && !reset) begin
            case (op)
                OP_ADDI: begin reg_we = 1'b1; add_b_sel = 1'b1; end
                OP_MACI: reg_we = 1'b1;
                OP_IN:   begin reg_we = 1'b1; in_en = 1'b1; end
                OP_ACCI: begin acc_en = 1'b1; acc_add = 1'b1; add_b_sel = 1'b1; end
                OP_ACCM: acc_en = 1'b1;
                OP_BSW:  begin add_a_sel = 1'b1; add_b_sel = 1'b1; end
                default: ;
            endcase
        end
    end

    assign halted = (state == S_HALT);

    // ---------------- sequencing registers ----------------
    always_ff @(posedge clk) begin
        if (reset) begin
            pc      <= '0;
            ir      <= 16'h0000;
            z_flag  <= 1'b0;
            illegal <= 1'b0;
        end else begin
            if (state == S_DECODE) ir <= instr;
            if (state == S_EXEC) begin
                pc <= pc_nx;
                if (op_sets_z)  z_flag  <= z;
                if (op_illegal) illegal <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_as_ctrl_seq.sv
module tb_as_ctrl_seq;

    logic        clk = 1'b0;
    logic        reset, run, step, z;
    logic [15:0] instr;
    logic [5:0]  pc;
    logic [1:0]  rd_addr, rs_addr;
    logic [7:0]  immediate;
    logic        reg_we, add_a_sel, add_b_sel, acc_en, acc_add, in_en, halted, illegal;

    as_ctrl_seq #(.n(8), .ADDR_W(6)) dut (
        .clk(clk), .reset(reset), .run(run), .step(step), .instr(instr), .z(z),
        .pc(pc), .rd_addr(rd_addr), .rs_addr(rs_addr), .immediate(immediate),
        .reg_we(reg_we), .add_a_sel(add_a_sel), .add_b_sel(add_b_sel),
        .acc_en(acc_en), .acc_add(acc_add), .in_en(in_en),
        .halted(halted), .illegal(illegal)
    );

    always #5 clk = ~clk;

    logic [15:0] rom [0:63];
    always @(posedge clk) instr <= rom[pc];

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- instruction-level reference model ----------------
    // phase: 0 waiting to fetch, 1 fetch issued, 2 executing, 3 halted
    int          m_ph, m_pc;
    logic [15:0] m_ir;
    bit          m_zf, m_ill;

    // {reg_we, add_a_sel, add_b_sel, acc_en, acc_add, in_en} per opcode
    function automatic logic [5:0] strobes(input int op);
        case (op)
            1:       return 6'b101000;
            2:       return 6'b100000;
            3:       return 6'b100001;
            4:       return 6'b001110;
            5:       return 6'b000100;
            6:       return 6'b011000;
            default: return 6'b000000;
        endcase
    endfunction

    always @(posedge clk) begin
        int op, imm;
        if (reset) begin
            m_ph = 0; m_pc = 0; m_ir = 16'h0; m_zf = 0; m_ill = 0;
        end else begin
            case (m_ph)
                0: if (run || step) m_ph = 1;
                1: begin m_ir = rom[m_pc]; m_ph = 2; end
                2: begin
                    op  = int'(m_ir[15:12]);
                    imm = int'(m_ir[7:0]) % 64;
                    if (op == 7)                          m_pc = imm;
                    else if (op == 8)                     m_pc = m_zf ? imm : (m_pc + 1) % 64;
                    else if (op != 15)                    m_pc = (m_pc + 1) % 64;
                    if (op == 1 || op == 2 || op == 4 || op == 5 || op == 6) m_zf = z;
                    if (op >= 9 && op <= 14)              m_ill = 1;
                    m_ph = (op == 15) ? 3 : 0;
                end
                default: ;
            endcase
        end
    end

    always @(negedge clk) begin
        logic [5:0] es;
        if (chk_en) begin
            es = (reset || m_ph != 2) ? 6'b0 : strobes(int'(m_ir[15:12]));
            chk("m_strobes", {reg_we, add_a_sel, add_b_sel, acc_en, acc_add, in_en}, es);
            chk("m_pc", pc, m_pc[5:0]);
            chk("m_fields", {rd_addr, rs_addr, immediate}, {m_ir[11:8], m_ir[7:0]});
            chk("m_halted", halted, (m_ph == 3));
            chk("m_illegal", illegal, m_ill);
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic rom_clear();
        for (int i = 0; i < 64; i++) rom[i] = 16'h0000;
    endtask

    task automatic do_reset();
        reset = 1'b1; run = 1'b0; step = 1'b0;
        tick();
        tick();
    endtask

    task automatic ticks(input int k);
        for (int i = 0; i < k; i++) tick();
    endtask

    initial begin
        int cnt;
        reset = 1'b1; run = 1'b0; step = 1'b0; z = 1'b0;
        rom_clear();
        tick();
        chk_en = 1'b1;

        // ADDI r1,#5: strobe only in cycle 3, pc=1 in cycle 4
        do_reset();
        rom_clear(); rom[0] = 16'h1405;
        #1 chk("rst_pc", pc, 0);
        chk("rst_illegal", illegal, 0);
        chk("rst_halted", halted, 0);
        #0 reset = 1'b0; run = 1'b1;
        #1 chk("addi_c1_we", reg_we, 0);
        tick(); #1 chk("addi_c2_we", reg_we, 0);
        tick(); #1 chk("addi_c3_we", reg_we, 1);
        chk("addi_c3_rd", rd_addr, 1);
        chk("addi_c3_bsel", add_b_sel, 1);
        chk("addi_c3_imm", immediate, 8'h05);
        tick(); #1 chk("addi_c4_pc", pc, 1);
        chk("addi_c4_we", reg_we, 0);

        // single step: nothing moves without step, one step = one instruction
        do_reset();
        rom_clear(); rom[0] = 16'h1405; rom[1] = 16'h1405;
        reset = 1'b0; run = 1'b0;
        ticks(20);
        #1 chk("idle_pc", pc, 0);
        chk("idle_we", reg_we, 0);
        #0 step = 1'b1;
        tick(); step = 1'b0;
        cnt = 0;
        for (int i = 0; i < 12; i++) begin
            #1 if (reg_we) cnt++;
            tick();
        end
        chk("step_we_count", cnt, 1);
        chk("step_pc", pc, 1);

        // BSW #1 then BZ #12, with z=1 and z=0
        for (int zz = 1; zz >= 0; zz--) begin
            do_reset();
            rom_clear(); rom[0] = 16'h6001; rom[1] = 16'h800C;
            z = zz[0]; reset = 1'b0; run = 1'b1;
            ticks(6);
            #1 chk(zz ? "bz_taken_pc" : "bz_not_taken_pc", pc, zz ? 12 : 2);
        end
        z = 1'b0;

        // illegal opcode, then HALT freezes pc, reset clears all
        do_reset();
        rom_clear(); rom[0] = 16'hA000; rom[2] = 16'hF000;
        reset = 1'b0; run = 1'b1;
        ticks(3);
        #1 chk("ill_set", illegal, 1);
        ticks(9);
        #1 chk("halt_flag", halted, 1);
        chk("halt_pc", pc, 2);
        chk("ill_sticky", illegal, 1);
        #0 step = 1'b1;
        ticks(5);
        step = 1'b0;
        #1 chk("halt_pc_frozen", pc, 2);
        #0 reset = 1'b1;
        tick();
        #1 chk("halt_rst_pc", pc, 0);
        chk("halt_rst_halted", halted, 0);
        chk("halt_rst_ill", illegal, 0);

        // reset landing in EXECUTE of ACCI
        do_reset();
        rom_clear(); rom[0] = 16'h4003;
        reset = 1'b0; run = 1'b1;
        ticks(2);
        #1 chk("acci_en", acc_en, 1);
        #0 reset = 1'b1;
        #1 chk("acci_rst_en", acc_en, 0);
        chk("acci_rst_add", acc_add, 0);
        tick();
        #1 chk("acci_rst_pc", pc, 0);
        chk("acci_rst_en2", acc_en, 0);

        // pc wrap: JMP #63, NOP at 63 -> 0
        do_reset();
        rom_clear(); rom[0] = 16'h703F;
        reset = 1'b0; run = 1'b1;
        ticks(3);
        #1 chk("wrap_pc63", pc, 63);
        ticks(3);
        #1 chk("wrap_pc0", pc, 0);

        // mixed program with a wandering z, checked by the model only
        do_reset();
        rom_clear();
        rom[0] = 16'h3800; rom[1] = 16'h2501; rom[2] = 16'h5102; rom[3] = 16'h1FFF;
        rom[4] = 16'h6001; rom[5] = 16'h8014; rom[6] = 16'h7000;
        rom[20] = 16'h4001; rom[21] = 16'h9123; rom[22] = 16'h7000;
        reset = 1'b0; run = 1'b1;
        for (int i = 0; i < 80; i++) begin
            z = 1'($urandom_range(0, 1));
            tick();
        end

        reset = 1'b1; run = 1'b0;
        tick();
        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
